// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the memory-mapped divider peripheral.
package div_pkg;

  localparam int unsigned DIV_WIDTH  = 32;
  localparam int unsigned DIV_ADDR_W = 5;

  localparam logic [DIV_ADDR_W-1:0] DIV_A      = 5'h00;
  localparam logic [DIV_ADDR_W-1:0] DIV_B      = 5'h04;
  localparam logic [DIV_ADDR_W-1:0] DIV_CTRL   = 5'h08;
  localparam logic [DIV_ADDR_W-1:0] DIV_STATUS = 5'h0C;
  localparam logic [DIV_ADDR_W-1:0] DIV_Q      = 5'h10;
  localparam logic [DIV_ADDR_W-1:0] DIV_R      = 5'h14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_core.sv
// Sequential restoring unsigned divider: one quotient bit per clock.
module div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;

  // Partial remainder is one bit wider than the operands so the compare cannot overflow.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    q_d     = q_q;
    r_d     = r_q;
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    rem_sub = rem_sh[WIDTH-1:0] - dvs_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dvd_d = a;
        dvs_d = b;
        rem_d = '0;
        quo_d = '0;
        cnt_d = CNT_W'(WIDTH - 1);
        if (b == '0) begin
          // Divide by zero follows the RISC-V result convention.
          quo_d   = '1;
          rem_d   = a;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = rem_sub;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        q_d     = quo_q;
        r_d     = rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;

endmodule

// File: rtl/peripheral_div.sv
// Bus front end of the divider: operand registers, start decode and registered read mux.
module peripheral_div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DIV_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]      d_in,
  output logic [WIDTH-1:0]      d_out
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             start_c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  assign start_c = cs && wr && (addr == DIV_CTRL) && d_in[0];

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .a     (a_q),
    .b     (b_q),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      d_out_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      d_out_q <= d_out_d;
    end
  end

  // Reads sample pre-edge register values; idle cycles drive zero for the OR-ed SoC read bus.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    d_out_d = '0;
    if (cs && wr) begin
      unique case (addr)
        DIV_A:   a_d = d_in;
        DIV_B:   b_d = d_in;
        default: ;
      endcase
    end
    if (cs && rd) begin
      unique case (addr)
        DIV_A:      d_out_d = a_q;
        DIV_B:      d_out_d = b_q;
        DIV_CTRL:   d_out_d = WIDTH'(busy);
        DIV_STATUS: d_out_d = WIDTH'({busy, done});
        DIV_Q:      d_out_d = q;
        DIV_R:      d_out_d = r;
        default:    d_out_d = '0;
      endcase
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_div.sv
// Directed bench for peripheral_div with a read-response scoreboard.
module tb_peripheral_div;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [4:0]  addr;
  logic [31:0] d_in;
  logic [31:0] d_out;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  peripheral_div dut (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, d_out, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    tick();
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic rd_reg(input logic [4:0] a, input logic [31:0] exp, input string tag);
    cs = 1'b1; rd = 1'b1; addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    cs = 1'b0; rd = 1'b0;
    check_out();
  endtask

  task automatic wait_done(input string tag);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      cs = 1'b1; rd = 1'b1; addr = DIV_STATUS;
      tick();
      cs = 1'b0; rd = 1'b0;
      seen = d_out[0];
      n++;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input string tag);
    wr_reg(DIV_A, a);
    wr_reg(DIV_B, b);
    wr_reg(DIV_CTRL, 32'd1);
    wait_done({tag, "_done"});
    rd_reg(DIV_Q, eq, {tag, "_q"});
    rd_reg(DIV_R, er, {tag, "_r"});
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    idle(2);
    rst = 1'b0;

    // Reset state
    check("rst_dout", d_out, 32'd0);
    rd_reg(DIV_A, 32'd0, "rst_a");
    rd_reg(DIV_STATUS, 32'd0, "rst_status");
    rd_reg(DIV_Q, 32'd0, "rst_q");

    // 100/7 with exact latency: start at edge N, done set at N+34
    wr_reg(DIV_A, 32'd100);
    wr_reg(DIV_B, 32'd7);
    rd_reg(DIV_B, 32'd7, "readback_b");
    wr_reg(DIV_CTRL, 32'd1);
    idle(33);
    rd_reg(DIV_STATUS, 32'h2, "lat_status_n34");
    rd_reg(DIV_STATUS, 32'h1, "lat_status_n35");
    check("idle_dout_zero", d_out, 32'd1);
    idle(1);
    check("idle_dout_cleared", d_out, 32'd0);
    rd_reg(DIV_Q, 32'd14, "d100_7_q");
    rd_reg(DIV_R, 32'd2, "d100_7_r");
    rd_reg(DIV_CTRL, 32'd0, "ctrl_idle");

    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "dmax_1");
    run_div(32'd5, 32'd9, 32'd0, 32'd5, "d5_9");
    run_div(32'hDEAD_BEEF, 32'h0001_0003, 32'hDEAD_BEEF / 32'h0001_0003,
            32'hDEAD_BEEF % 32'h0001_0003, "dbeef");

    // Divide by zero finishes two edges after start
    wr_reg(DIV_A, 32'h1234);
    wr_reg(DIV_B, 32'd0);
    wr_reg(DIV_CTRL, 32'd1);
    rd_reg(DIV_STATUS, 32'h2, "dz_status_n1");
    rd_reg(DIV_STATUS, 32'h2, "dz_status_n2");
    rd_reg(DIV_STATUS, 32'h1, "dz_status_n3");
    rd_reg(DIV_Q, 32'hFFFF_FFFF, "dz_q");
    rd_reg(DIV_R, 32'h1234, "dz_r");

    // Start while busy is ignored; B write lands but does not disturb the division
    wr_reg(DIV_A, 32'd100);
    wr_reg(DIV_B, 32'd7);
    wr_reg(DIV_CTRL, 32'd1);
    idle(8);
    wr_reg(DIV_B, 32'd3);
    wr_reg(DIV_CTRL, 32'd1);
    rd_reg(DIV_STATUS, 32'h2, "busy_status");
    rd_reg(DIV_CTRL, 32'h1, "busy_ctrl");
    rd_reg(DIV_B, 32'd3, "busy_b_write");
    rd_reg(DIV_Q, 32'hFFFF_FFFF, "q_hold_busy");
    wait_done("ign_done");
    rd_reg(DIV_Q, 32'd14, "ign_q");
    rd_reg(DIV_R, 32'd2, "ign_r");
    wr_reg(DIV_CTRL, 32'd1);
    rd_reg(DIV_Q, 32'd14, "q_hold_restart");
    wait_done("d100_3_done");
    rd_reg(DIV_Q, 32'd33, "d100_3_q");
    rd_reg(DIV_R, 32'd1, "d100_3_r");

    // Reset mid-operation
    wr_reg(DIV_B, 32'd7);
    wr_reg(DIV_CTRL, 32'd1);
    idle(13);
    cs = 1'b1; rd = 1'b1; addr = DIV_A;
    tick();
    cs = 1'b0; rd = 1'b0;
    check("pre_rst_dout", d_out, 32'd100);
    rst = 1'b1;
    #1;
    check("rst_async_dout", d_out, 32'd0);
    tick();
    rst = 1'b0;
    rd_reg(DIV_STATUS, 32'd0, "mid_rst_status");
    rd_reg(DIV_Q, 32'd0, "mid_rst_q");
    rd_reg(DIV_R, 32'd0, "mid_rst_r");
    rd_reg(DIV_A, 32'd0, "mid_rst_a");
    run_div(32'd50, 32'd5, 32'd10, 32'd0, "d50_5");

    // Chip select gating and unmapped offsets
    cs = 1'b0; wr = 1'b1; addr = DIV_A; d_in = 32'hDEAD_0000;
    tick();
    wr = 1'b0;
    rd_reg(DIV_A, 32'd50, "nocs_write");
    cs = 1'b0; rd = 1'b1; addr = DIV_A;
    tick();
    rd = 1'b0;
    check("nocs_read", d_out, 32'd0);
    wr_reg(5'h1C, 32'hFFFF_FFFF);
    rd_reg(5'h1C, 32'd0, "unmapped_1c");
    rd_reg(DIV_A, 32'd50, "unmapped_wr_a");

    // Simultaneous read and write returns the pre-write value
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = DIV_A; d_in = 32'd77;
    exp_q.push_back(32'd50);
    tag_q.push_back("rw_same_old");
    tick();
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    check_out();
    rd_reg(DIV_A, 32'd77, "rw_same_new");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
